// File: rtl/memory_responder_if.sv
// Request/response bundle between the control unit (MAR/MDR side) and the memory responder.
interface memory_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                  Read;
    logic                  Write;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] DataIn;
    logic [DATA_WIDTH-1:0] DataOut;
    logic                  Ready;
    logic                  Error;
    logic                  Busy;

    modport master (
        output Read, Write, Address, DataIn,
        input  DataOut, Ready, Error, Busy
    );

    modport slave (
        input  Read, Write, Address, DataIn,
        output DataOut, Ready, Error, Busy
    );
endinterface

// File: rtl/memory_responder.sv
// Word RAM with WAIT_CYCLES wait states; Ready pulses at edge WAIT_CYCLES+1 after the request edge.
// Strobe edges arriving while busy are dropped; all outputs are registered.
module memory_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    memory_responder_if.slave bus
);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                state;
    logic                  rd_q;
    logic                  wr_q;
    logic                  op_wr;
    logic                  err_q;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] dout;
    logic                  ready;
    logic                  error;
    logic                  busy;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic rd_req;
    logic wr_req;
    logic out_of_range;
    logic do_access;

    assign rd_req       = bus.Read & ~rd_q;
    assign wr_req       = bus.Write & ~wr_q;
    assign out_of_range = {1'b0, bus.Address} >= (ADDR_WIDTH + 1)'(DEPTH);
    assign do_access    = (state == S_WAIT) && (cnt == '0) && !err_q;

    assign bus.DataOut = dout;
    assign bus.Ready   = ready;
    assign bus.Error   = error;
    assign bus.Busy    = busy;

    // Contents survive reset; a reset on the access edge suppresses the store.
    always_ff @(posedge Clock) begin
        if (!Reset && do_access && op_wr) begin
            mem[addr_q] <= data_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= S_IDLE;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            op_wr  <= 1'b0;
            err_q  <= 1'b0;
            cnt    <= '0;
            addr_q <= '0;
            data_q <= '0;
            dout   <= '0;
            ready  <= 1'b0;
            error  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            rd_q <= bus.Read;
            wr_q <= bus.Write;
            case (state)
                S_IDLE: begin
                    if (rd_req || wr_req) begin
                        busy  <= 1'b1;
                        state <= S_WAIT;
                        // Rejected requests spend one zero-count wait cycle so Ready lands after E1.
                        if ((rd_req && wr_req) || out_of_range) begin
                            err_q <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            addr_q <= bus.Address;
                            data_q <= bus.DataIn;
                            op_wr  <= wr_req;
                            cnt    <= CW'(WAIT_CYCLES);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        if (do_access && !op_wr) begin
                            dout <= mem[addr_q];
                        end
                        ready <= 1'b1;
                        error <= err_q;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    ready <= 1'b0;
                    error <= 1'b0;
                    err_q <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
